// File: rtl/cv32e40p_imem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cv32e40p_imem_arbiter_if
// Bundle of the three buses around the instruction memory arbiter:
//   fetch_* : IF-stage read port (req/addr/flush in, gnt/rvalid/rdata out)
//   ext_*   : debug/loader read-write port (req/we/be/addr/wdata in,
//             gnt/rvalid/rdata out)
//   mem_*   : single-port synchronous memory (req/we/be/addr/wdata out,
//             rdata in, valid one cycle after a read access)
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding system's view (requesters plus memory)
// ---------------------------------------------------------------------------
interface cv32e40p_imem_arbiter_if;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_flush_i;
  logic        fetch_gnt_o;
  logic        fetch_rvalid_o;
  logic [31:0] fetch_rdata_o;

  logic        ext_req_i;
  logic        ext_we_i;
  logic [3:0]  ext_be_i;
  logic [31:0] ext_addr_i;
  logic [31:0] ext_wdata_i;
  logic        ext_gnt_o;
  logic        ext_rvalid_o;
  logic [31:0] ext_rdata_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i, fetch_flush_i,
    output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
    input  ext_req_i, ext_we_i, ext_be_i, ext_addr_i, ext_wdata_i,
    output ext_gnt_o, ext_rvalid_o, ext_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output fetch_req_i, fetch_addr_i, fetch_flush_i,
    input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
    output ext_req_i, ext_we_i, ext_be_i, ext_addr_i, ext_wdata_i,
    input  ext_gnt_o, ext_rvalid_o, ext_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/cv32e40p_imem_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40p_imem_arbiter
// Shares one single-port synchronous instruction memory between the core
// fetch port and an external (debug / loader) port. Grants are combinational
// from the requests; read data returns exactly one cycle after the grant.
// Fetch has priority unless the external port has been blocked MAX_WAIT
// cycles, in which case it is forced through. A fetch flush suppresses the
// response to the fetch granted in the previous cycle.
// Parameters:
//   MAX_WAIT : blocked cycles before the external port wins (1..15)
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; forces every output to 0
//   bus   : fetch / ext / mem buses (slave modport)
// ---------------------------------------------------------------------------
module cv32e40p_imem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  cv32e40p_imem_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_FETCH,
    RESP_EXT_R,
    RESP_EXT_W
  } resp_e;

  resp_e      resp_q;
  logic [3:0] ext_wait_q;
  logic       ext_prio;
  logic       fetch_gnt;
  logic       ext_gnt;

  assign ext_prio = (ext_wait_q == WAIT_LIMIT);

  // Grants are gated by rst_n so nothing reaches the memory while in reset,
  // even with requests already asserted.
  always_comb begin
    fetch_gnt = 1'b0;
    ext_gnt   = 1'b0;
    if (rst_n) begin
      if (bus.ext_req_i && (ext_prio || !bus.fetch_req_i)) begin
        ext_gnt = 1'b1;
      end else if (bus.fetch_req_i) begin
        fetch_gnt = 1'b1;
      end
    end
  end

  assign bus.fetch_gnt_o = fetch_gnt;
  assign bus.ext_gnt_o   = ext_gnt;

  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'h0;
    bus.mem_addr_o  = 32'h0;
    bus.mem_wdata_o = 32'h0;
    if (ext_gnt) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_we_o    = bus.ext_we_i;
      bus.mem_be_o    = bus.ext_be_i;
      bus.mem_addr_o  = {bus.ext_addr_i[31:2], 2'b00};
      bus.mem_wdata_o = bus.ext_wdata_i;
    end else if (fetch_gnt) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_be_o    = 4'hF;
      bus.mem_addr_o  = {bus.fetch_addr_i[31:2], 2'b00};
    end
  end

  // resp_q records who owns the memory read data arriving next cycle.
  // ext_wait_q counts consecutive blocked external cycles and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q     <= RESP_IDLE;
      ext_wait_q <= 4'h0;
    end else begin
      if (ext_gnt) begin
        resp_q <= bus.ext_we_i ? RESP_EXT_W : RESP_EXT_R;
      end else if (fetch_gnt) begin
        resp_q <= RESP_FETCH;
      end else begin
        resp_q <= RESP_IDLE;
      end

      if (bus.ext_req_i && !ext_gnt) begin
        if (ext_wait_q != WAIT_LIMIT) begin
          ext_wait_q <= ext_wait_q + 4'h1;
        end
      end else begin
        ext_wait_q <= 4'h0;
      end
    end
  end

  // Flush only masks the response of the previous-cycle fetch; it never
  // touches resp_q, so a fetch granted alongside the flush still returns.
  assign bus.fetch_rvalid_o = (resp_q == RESP_FETCH) && !bus.fetch_flush_i;
  assign bus.fetch_rdata_o  = bus.fetch_rvalid_o ? bus.mem_rdata_i : 32'h0;
  assign bus.ext_rvalid_o   = (resp_q == RESP_EXT_R) || (resp_q == RESP_EXT_W);
  assign bus.ext_rdata_o    = (resp_q == RESP_EXT_R) ? bus.mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_cv32e40p_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_imem_arbiter
// Directed bench for cv32e40p_imem_arbiter. Each tick drives one cycle of
// requests, checks the combinational grant and memory outputs, and queues
// the expected responses. A separate monitor compares rvalid/rdata of both
// ports every cycle against the queues. The memory model returns
// addr ^ 32'hC0DE_0000 after an access and 32'hFFFF_FFFF after idle cycles.
// ---------------------------------------------------------------------------
module tb_cv32e40p_imem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t fq[$];
  exp_t eq[$];

  cv32e40p_imem_arbiter_if bus ();

  cv32e40p_imem_arbiter #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    bus.mem_rdata_i <= bus.mem_req_o ? (bus.mem_addr_o ^ 32'hC0DE_0000) : 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ed;
    #2;
    ev = (fq.size() > 0) && (fq[0].cyc == cyc);
    ed = ev ? fq[0].data : 32'h0;
    check("fetch_rvalid", 32'(bus.fetch_rvalid_o), 32'(ev));
    check("fetch_rdata", bus.fetch_rdata_o, ed);
    if (ev) void'(fq.pop_front());
    ev = (eq.size() > 0) && (eq[0].cyc == cyc);
    ed = ev ? eq[0].data : 32'h0;
    check("ext_rvalid", 32'(bus.ext_rvalid_o), 32'(ev));
    check("ext_rdata", bus.ext_rdata_o, ed);
    if (ev) void'(eq.pop_front());
  end

  // One cycle: drive inputs, check grants/memory outputs, queue responses.
  task automatic tick(input logic rst, input logic fr, input logic [31:0] fa, input logic fl,
                      input logic er, input logic ew, input logic [3:0] eb,
                      input logic [31:0] ea, input logic [31:0] ewd,
                      input logic xfg, input logic xeg,
                      input logic fv, input logic [31:0] fd,
                      input logic ev, input logic [31:0] ed);
    logic        x_req, x_we;
    logic [3:0]  x_be;
    logic [31:0] x_addr, x_wdata;
    @(negedge clk);
    rst_n             = rst;
    bus.fetch_req_i   = fr;
    bus.fetch_addr_i  = fa;
    bus.fetch_flush_i = fl;
    bus.ext_req_i     = er;
    bus.ext_we_i      = ew;
    bus.ext_be_i      = eb;
    bus.ext_addr_i    = ea;
    bus.ext_wdata_i   = ewd;
    #1;
    x_req = xfg | xeg;
    x_we = 1'b0; x_be = 4'h0; x_addr = 32'h0; x_wdata = 32'h0;
    if (xeg) begin
      x_we = ew; x_be = eb; x_addr = {ea[31:2], 2'b00}; x_wdata = ewd;
    end else if (xfg) begin
      x_be = 4'hF; x_addr = {fa[31:2], 2'b00};
    end
    check("fetch_gnt", 32'(bus.fetch_gnt_o), 32'(xfg));
    check("ext_gnt", 32'(bus.ext_gnt_o), 32'(xeg));
    check("mem_req", 32'(bus.mem_req_o), 32'(x_req));
    check("mem_we", 32'(bus.mem_we_o), 32'(x_we));
    check("mem_be", 32'(bus.mem_be_o), 32'(x_be));
    check("mem_addr", bus.mem_addr_o, x_addr);
    check("mem_wdata", bus.mem_wdata_o, x_wdata);
    if (fv) fq.push_back('{cyc + 1, fd});
    if (ev) eq.push_back('{cyc + 1, ed});
  endtask

  initial begin
    bus.fetch_req_i   = 1'b1;
    bus.fetch_addr_i  = 32'h0;
    bus.fetch_flush_i = 1'b0;
    bus.ext_req_i     = 1'b1;
    bus.ext_we_i      = 1'b0;
    bus.ext_be_i      = 4'hF;
    bus.ext_addr_i    = 32'h100;
    bus.ext_wdata_i   = 32'h0;

    // reset with both requests asserted: everything held at 0
    tick(0, 1, 32'h0, 0, 1, 0, 4'hF, 32'h100, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick(0, 1, 32'h0, 0, 1, 0, 4'hF, 32'h100, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);

    // fetch only
    tick(1, 1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'hC0DE_0000, 0, 32'h0);
    tick(1, 1, 32'h4, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'hC0DE_0004, 0, 32'h0);
    tick(1, 1, 32'h8, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'hC0DE_0008, 0, 32'h0);

    // continuous fetch vs. held ext read: 4 blocked, 5th granted
    tick(1, 1, 32'hC,  0, 1, 0, 4'hF, 32'h100, 32'h1234_5678, 1, 0, 1, 32'hC0DE_000C, 0, 32'h0);
    tick(1, 1, 32'h10, 0, 1, 0, 4'hF, 32'h100, 32'h1234_5678, 1, 0, 1, 32'hC0DE_0010, 0, 32'h0);
    tick(1, 1, 32'h14, 0, 1, 0, 4'hF, 32'h100, 32'h1234_5678, 1, 0, 1, 32'hC0DE_0014, 0, 32'h0);
    tick(1, 1, 32'h18, 0, 1, 0, 4'hF, 32'h100, 32'h1234_5678, 1, 0, 1, 32'hC0DE_0018, 0, 32'h0);
    tick(1, 1, 32'h1C, 0, 1, 0, 4'hF, 32'h100, 32'h1234_5678, 0, 1, 0, 32'h0, 1, 32'hC0DE_0100);
    tick(1, 1, 32'h1C, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'hC0DE_001C, 0, 32'h0);

    // ext write, unaligned address, partial byte enables
    tick(1, 0, 32'h0, 0, 1, 1, 4'b0011, 32'h203, 32'hDEAD_BEEF, 0, 1, 0, 32'h0, 1, 32'h0);

    // flush kills the 0x40 response, the 0x80 fetch granted with it survives
    tick(1, 1, 32'h40, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0);
    tick(1, 1, 32'h80, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'hC0DE_0080, 0, 32'h0);

    // flush does not touch an external read response
    tick(1, 0, 32'h0, 0, 1, 0, 4'hF, 32'h300, 32'h0, 0, 1, 0, 32'h0, 1, 32'hC0DE_0300);
    tick(1, 0, 32'h0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);

    // partial starvation, reset the cycle after a grant, then full wait again
    tick(1, 1, 32'h20, 0, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 1, 32'hC0DE_0020, 0, 32'h0);
    tick(1, 1, 32'h24, 0, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 1, 32'hC0DE_0024, 0, 32'h0);
    tick(1, 1, 32'h28, 0, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0);
    tick(0, 1, 32'h2C, 0, 1, 0, 4'hF, 32'h500, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick(1, 1, 32'h2C, 0, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 1, 32'hC0DE_002C, 0, 32'h0);
    tick(1, 1, 32'h30, 0, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 1, 32'hC0DE_0030, 0, 32'h0);
    tick(1, 1, 32'h34, 0, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 1, 32'hC0DE_0034, 0, 32'h0);
    tick(1, 1, 32'h38, 0, 1, 0, 4'hF, 32'h500, 32'h0, 1, 0, 1, 32'hC0DE_0038, 0, 32'h0);
    tick(1, 1, 32'h3C, 0, 1, 0, 4'hF, 32'h500, 32'h0, 0, 1, 0, 32'h0, 1, 32'hC0DE_0500);
    tick(1, 1, 32'h3C, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'hC0DE_003C, 0, 32'h0);

    // drain
    tick(1, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick(1, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    #3;
    check("fetch_pending", 32'(fq.size()), 32'h0);
    check("ext_pending", 32'(eq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_imem_arbiter.md
# cv32e40p_imem_arbiter

Arbitrates one single-port, synchronous instruction memory between the core fetch port (IF stage) and an external read/write port (debug module / program loader). Requests are granted in the same cycle. Read data returns exactly one cycle after the grant. Fetch has priority by default, and a starvation counter guarantees the external port a bounded wait. A fetch flush (PC redirect) discards stale fetch responses so the IF/ID pipeline never sees data from a pre-redirect address.

## Interface
- MAX_WAIT, 4: cycles a pending external request may be blocked before it takes forced priority; legal range 1..15.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- fetch_req_i  in  1  fetch read request
- fetch_addr_i  in  32  fetch word address; bits [1:0] ignored
- fetch_flush_i  in  1  PC redirect; kills fetch responses to earlier grants
- fetch_gnt_o  out  1  fetch request accepted this cycle
- fetch_rvalid_o  out  1  fetch read data valid
- fetch_rdata_o  out  32  fetch read data
- ext_req_i  in  1  external request
- ext_we_i  in  1  1 = write, 0 = read
- ext_be_i  in  4  byte enables for writes
- ext_addr_i  in  32  external address; bits [1:0] ignored
- ext_wdata_i  in  32  write data
- ext_gnt_o  out  1  external request accepted this cycle
- ext_rvalid_o  out  1  response valid; acknowledges both reads and writes
- ext_rdata_o  out  32  read data; 0 for write responses
- mem_req_o  out  1  memory access this cycle
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  word-aligned address, {addr[31:2], 2'b00}
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid the cycle after a read access

## Operation
- At most one grant per cycle. Full throughput: back-to-back grants are allowed every cycle.
- Priority:
  - Fetch wins when both requesters are active.
  - If ext_wait_q == MAX_WAIT, external wins instead.
  - A single active requester is always granted.
- ext_wait_q (4 bits):
  - Increments when ext_req_i=1 and ext_gnt_o=0.
  - Clears on ext_gnt_o or when ext_req_i=0.
  - Saturates at MAX_WAIT.
- Memory outputs:
  - mem_req_o = fetch_gnt_o | ext_gnt_o.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o come from the granted port.
  - A fetch access is a read with be=4'hF.
  - All memory outputs are 0 when mem_req_o=0.
- Response-owner state resp_q, loaded every cycle from that cycle's grant:
  - IDLE: no grant.
  - FETCH: fetch granted.
  - EXT_R: external read granted.
  - EXT_W: external write granted.
- Response outputs:
  - fetch_rvalid_o = (resp_q==FETCH) & ~fetch_flush_i. fetch_rdata_o = mem_rdata_i when fetch_rvalid_o, else 0.
  - ext_rvalid_o = resp_q ∈ {EXT_R, EXT_W}. ext_rdata_o = mem_rdata_i in EXT_R, 0 otherwise.
- Flush: a fetch_flush_i in cycle N kills only the response for a fetch granted in cycle N-1. A fetch granted in cycle N (the new PC) is unaffected and returns in N+1. Flush never affects the external port or the grant logic.
- No combinational path from mem_rdata_i to any grant or memory request output.

## Timing
- Reset (rst_n=0):
  - resp_q=IDLE, ext_wait_q=0.
  - All outputs are forced 0, including grants and mem_req_o, regardless of inputs.
- Grant latency: 0 cycles, combinational from the request.
- Response latency: exactly 1 cycle after the grant, for every granted access.
- Requesters hold req and address/data stable until granted. The arbiter does not register requests.
- Worst-case external wait under continuous fetch: MAX_WAIT cycles blocked, granted in cycle MAX_WAIT+1. The blocked fetch is granted the following cycle at the earliest.
- Reset asserted mid-access: the pending response is discarded and no rvalid follows after reset release.
- Simultaneous rvalid and new grant to the same port is legal, since the response and the next request overlap every cycle.

## Test plan
- Fetch only, fetch_req_i=1 continuously, addresses 0x0, 0x4, 0x8 -> fetch_gnt_o=1 every cycle; fetch_rvalid_o=1 one cycle later with the matching mem_rdata_i; mem_be_o=4'hF, mem_we_o=0.
- Continuous fetch with ext read to 0x100 held, MAX_WAIT=4 -> ext blocked for 4 cycles, granted in the 5th cycle with mem_addr_o=0x100; ext_rvalid_o=1 the next cycle; fetch re-granted the cycle after the ext grant.
- Ext write of 0xDEADBEEF, be=4'b0011, to address 0x203 -> mem_addr_o=0x200, mem_we_o=1, mem_be_o=4'b0011; ext_rvalid_o=1 with ext_rdata_o=0 one cycle later.
- Fetch granted at 0x40 in cycle N, fetch_flush_i=1 with a fetch of 0x80 in cycle N+1 -> no fetch_rvalid_o in N+1; fetch_rvalid_o=1 in N+2 with the 0x80 data.
- Flush while resp_q=EXT_R -> ext_rvalid_o still 1 with correct data.
- rst_n asserted the cycle after a grant -> all outputs 0 immediately; after release, no rvalid before a new grant and ext_wait_q restarts from 0.
